// File: rtl/downcount_pkg.sv
//------------------------------------------------------------------------------
// downcount_pkg
// Shared state encoding and constants for the loadable down-count timer.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package downcount_pkg;

  localparam int unsigned c_MAX_WIDTH = 16;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = c_ST_IDLE,
    RUN  = c_ST_RUN,
    DONE = c_ST_DONE
  } state_t;

  // Wide enough for any legal WIDTH; users slice [WIDTH-1:0].
  localparam logic [c_MAX_WIDTH-1:0] c_ZERO = '0;

endpackage : downcount_pkg

`default_nettype wire

// File: rtl/downcount_timer.sv
//------------------------------------------------------------------------------
// downcount_timer
// Loadable down-counter with start/stop/pause control, terminal-count pulse
// and optional auto-reload.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module downcount_timer
  import downcount_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_ZERO_W = c_ZERO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  logic w_count_zero;
  assign w_count_zero = (r_count == c_ZERO_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= c_ZERO_W;
      r_reload <= c_ZERO_W;
      r_state  <= IDLE;
      r_tc     <= 1'b0;
    end else if (load) begin
      r_count  <= data_in;
      r_reload <= data_in;
      r_state  <= IDLE;
      r_tc     <= 1'b0;
    end else if (stop) begin
      r_state  <= IDLE;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // A zero count has nothing to time, so start is ignored.
          if (start && !w_count_zero) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!pause) begin
            if (r_count > c_ONE_W) begin
              r_count <= r_count - c_ONE_W;
            end else if (r_count == c_ONE_W) begin
              r_count <= c_ZERO_W;
              r_tc    <= 1'b1;
              if (!auto_reload) begin
                r_state <= DONE;
              end
            end else begin
              // Zero in RUN only follows a terminal count in periodic mode.
              r_count <= r_reload;
              if (r_reload == c_ZERO_W) begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);

endmodule : downcount_timer

`default_nettype wire

// File: tb/tb_downcount_timer.sv
//------------------------------------------------------------------------------
// tb_downcount_timer
// Directed self-checking bench for downcount_timer (WIDTH = 4).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_downcount_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  int n_cmp;
  int n_err;

  downcount_timer #(.WIDTH(WIDTH)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data_in     (data_in),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_count, input int e_busy,
                         input int e_tc, input int e_done);
    chk({tag, ".count"}, 32'(count), 32'(e_count));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".tc"},    32'(tc),    32'(e_tc));
    chk({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  initial begin
    int exp_ar_count [8];
    int exp_ar_tc    [8];
    exp_ar_count = '{2, 1, 0, 3, 2, 1, 0, 3};
    exp_ar_tc    = '{0, 0, 1, 0, 0, 0, 1, 0};
    n_cmp = 0;
    n_err = 0;

    // Reset with noisy control inputs
    rst = 1'b1; load = 1'b1; data_in = 4'd7; start = 1'b1;
    stop = 1'b0; pause = 1'b0; auto_reload = 1'b1;
    step();
    step();
    rst = 1'b0; load = 1'b0; start = 1'b0; auto_reload = 1'b0;
    chk_all("reset", 0, 0, 0, 0);

    // One-shot from 5
    load = 1'b1; data_in = 4'd5;
    step();
    load = 1'b0;
    chk_all("os_load", 5, 0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("os_start", 5, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("os_k%0d", k), 5 - k, (k == 5) ? 0 : 1,
              (k == 5) ? 1 : 0, (k == 5) ? 1 : 0);
    end
    step();
    chk_all("os_hold", 0, 0, 0, 1);

    // Auto-reload from 3
    load = 1'b1; data_in = 4'd3;
    step();
    load = 1'b0; auto_reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("ar_start", 3, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all($sformatf("ar_k%0d", k), exp_ar_count[k], 1, exp_ar_tc[k], 0);
    end
    auto_reload = 1'b0;
    step();
    step();
    chk_all("ar_clr_1", 1, 1, 0, 0);
    step();
    chk_all("ar_clr_end", 0, 0, 1, 1);

    // Pause and stop
    load = 1'b1; data_in = 4'd6;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk_all("ps_pre", 4, 1, 0, 0);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("ps_pause%0d", k), 4, 1, 0, 0);
    end
    pause = 1'b0;
    step();
    chk_all("ps_res3", 3, 1, 0, 0);
    step();
    chk_all("ps_res2", 2, 1, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("ps_stop", 2, 0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("ps_restart", 2, 1, 0, 0);
    step();
    chk_all("ps_1", 1, 1, 0, 0);
    step();
    chk_all("ps_end", 0, 0, 1, 1);

    // load beats start
    load = 1'b1; start = 1'b1; data_in = 4'd9;
    step();
    load = 1'b0; start = 1'b0;
    chk_all("prio_load", 9, 0, 0, 0);

    // start with a zero count is ignored
    load = 1'b1; data_in = 4'd0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("zero_start", 0, 0, 0, 0);
    auto_reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0; auto_reload = 1'b0;
    chk_all("zero_start_ar", 0, 0, 0, 0);

    // Reset mid-run
    load = 1'b1; data_in = 4'd15;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk_all("rr_pre", 10, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("rr_rst", 0, 0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("rr_start", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_downcount_timer

`default_nettype wire

// File: doc/downcount_timer.md
Name: downcount_timer

Overview:
- Synchronous, loadable, parameterised down-counter with a start/stop control FSM, a terminal-count pulse and optional auto-reload.
- It complements the team's loadable up-counter: software or a parent FSM loads a value and starts the timer.
- The block counts down to zero, then either stops with done asserted or reloads the stored value and repeats.
- Typical use is delay, timeout and periodic-tick generation.

Parameters:
- WIDTH, 4, counter and data width in bits (legal range 2..16).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load data_in into count and reload register.
- data_in  input  WIDTH  value to load.
- start  input  1  begin counting from current count.
- stop  input  1  abort counting; count holds its value.
- pause  input  1  freeze count while in RUN.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled every cycle.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while state == RUN.
- tc  output  1  registered one-cycle pulse, high in the cycle where count has just reached 0 from 1.
- done  output  1  high while state == DONE.

Behaviour:
- Reset is clocked: when rst=1 at a rising edge, count=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0.
- Control priority per edge: rst > load > stop > start > pause > normal counting.
- States: IDLE, RUN, DONE. busy and done are decoded from the registered state; tc is a register.
- load (any state): count<=data_in, reload_reg<=data_in, state<=IDLE, tc<=0.
- stop (any state): state<=IDLE, count held, tc<=0.
- start in IDLE or DONE with count!=0: state<=RUN, count unchanged. The first decrement occurs at the following edge.
- start with count==0: ignored; state unchanged.
- start while in RUN: no effect.
- RUN with pause=1: count and state held; tc<=0.
- RUN, pause=0, count>1: count<=count-1, tc<=0.
- RUN, pause=0, count==1: count<=0, tc<=1.
  - auto_reload=0: state<=DONE.
  - auto_reload=1: stay in RUN.
- RUN, pause=0, count==0 (reached only via auto-reload): count<=reload_reg, tc<=0.
  - If reload_reg==0, state<=IDLE instead.
- Latency: in one-shot mode with loaded value N, tc and done appear N edges after the start edge.
- Period: in auto-reload mode the tc period is N+1 cycles.
- Clearing auto_reload mid-RUN takes effect at the next count==1 edge.
- DONE: count=0 and held. Left only via load, stop, or start (start is ignored while count==0, so effectively load or stop).
- Arithmetic: unsigned WIDTH-bit values. There is no underflow, because the decrement at count==0 never occurs.
- Reset mid-RUN aborts immediately; the reload value is lost.

Decomposition:
- Shared package downcount_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam constants for the state encoding
  - a WIDTH-generic zero constant.
- No sub-module: the FSM, count register and reload register sit in one module.

Test Plan:
1. Reset: rst=1 for 2 edges with arbitrary inputs -> count=0, busy=0, done=0, tc=0.
2. One-shot: load 5, then start, auto_reload=0 -> busy=1.
   - count sequence 5,4,3,2,1,0.
   - tc=1 for exactly one cycle when count=0, 5 edges after start.
   - done=1 held; busy=0.
3. Auto-reload: load 3, start, auto_reload=1 -> count sequence 3,2,1,0,3,2,1,0...
   - tc pulses every 4 cycles.
   - busy stays 1.
   - Clearing auto_reload ends the sequence in DONE after the next 0.
4. Pause and stop: load 6, start, pause=1 for 3 cycles at count=4 -> count holds at 4.
   - Release pause -> counting resumes 3,2.
   - stop at count=2 -> IDLE, count=2, busy=0.
   - start -> resumes from 2.
5. Priority and edge cases:
   - load=1 and start=1 together with data_in=9 -> count=9, state IDLE.
   - start with count=0 -> ignored, busy=0.
   - load 0, auto_reload=1, start -> ignored.
6. Reset mid-RUN: load 15 (WIDTH=4), start, assert rst at count=10 -> next edge count=0, IDLE, tc=0, done=0.
   - A subsequent start is ignored because count=0.
